// File: rtl/booth_ctrl_unit_pkg.sv
// Shared types for the Booth multiplier control unit: FSM state encoding
// and the bit positions of the c0..c7 register control strobes.
package booth_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_M = 3'd1,
      S_LOAD_Q = 3'd2,
      S_OP     = 3'd3,
      S_SHIFT  = 3'd4,
      S_OUT_A  = 3'd5,
      S_OUT_Q  = 3'd6,
      S_END    = 3'd7
   } state_e;

   // Strobe indices: strobe vector bit n drives output cn.
   localparam int C_CLR_A   = 0;  // clear A
   localparam int C_LOAD_Q  = 1;  // load Q (multiplier) from inbus
   localparam int C_LOAD_M  = 2;  // load M (multiplicand) from inbus
   localparam int C_ADD     = 3;  // A <= A + M
   localparam int C_SHIFT   = 4;  // arithmetic shift right A:Q
   localparam int C_SUB     = 5;  // A <= A - M
   localparam int C_OUT_Q   = 6;  // Q onto outbus
   localparam int C_OUT_A   = 7;  // A onto outbus
   localparam int N_STROBES = 8;

endpackage

// File: rtl/booth_ctrl_unit_if.sv
// Handshake between the Booth control unit and its environment: the start
// request and Q[0] feedback in, register strobes and status out.
interface booth_ctrl_unit_if;
   logic start;
   logic q_lsb;
   logic c0, c1, c2, c3, c4, c5, c6, c7;
   logic busy;
   logic done;

   // Environment / datapath side.
   modport master (
      output start, q_lsb,
      input  c0, c1, c2, c3, c4, c5, c6, c7, busy, done
   );

   // Control unit side.
   modport slave (
      input  start, q_lsb,
      output c0, c1, c2, c3, c4, c5, c6, c7, busy, done
   );
endinterface

// File: rtl/booth_ctrl_unit_iter_cnt.sv
// Iteration counter for the Booth sequence: cleared at operand load,
// advanced once per shift, flags the final iteration (cnt == w-1).
module booth_iter_cnt #(
   parameter int w  = 16,
   parameter int CW = $clog2(w)
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr_i,
   input  logic inc_i,
   output logic last_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign last_o = (cnt_q == CW'(w - 1));

   // Next count: clear wins; holds at w-1 so it never wraps mid-operation.
   always_comb begin
      // NOTE: assign a default first in every always_comb so no path leaves the
      // output unassigned -- that is what would infer a latch.
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !last_o)
         cnt_d = cnt_q + 1'b1;
   end

   // Count register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_b) begin
      // NOTE: sequential state is updated with <= so every flop samples the
      // pre-edge values regardless of block evaluation order.
      if (!rst_b)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/booth_ctrl_unit.sv
// Sequencer for a radix-2 Booth signed multiplier: loads M and Q, runs w
// add/subtract-and-shift iterations, drives A then Q onto outbus, pulses done.
// Holds the Booth Q[-1] flop (qm1), refreshed from q_lsb on every shift.
module booth_ctrl_unit
   import booth_pkg::*;
#(
   parameter int w = 16
) (
   input  logic            clk,
   input  logic            rst_b,
   booth_ctrl_unit_if.slave bus
);

   localparam int CW = $clog2(w);

   state_e                 state_q, state_d;
   logic                   qm1_q, qm1_d;
   logic                   cnt_last;
   logic [N_STROBES-1:0]   strobe;

   booth_iter_cnt #(.w(w), .CW(CW)) u_iter_cnt (
      .clk    (clk),
      .rst_b  (rst_b),
      .clr_i  (state_q == S_LOAD_M),
      .inc_i  (state_q == S_SHIFT),
      .last_o (cnt_last)
   );

   // Next-state and Q[-1] update; start is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      qm1_d   = qm1_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_LOAD_M;
         S_LOAD_M: begin
            qm1_d   = 1'b0;
            state_d = S_LOAD_Q;
         end
         S_LOAD_Q: state_d = S_OP;
         S_OP:     state_d = S_SHIFT;
         S_SHIFT:  begin
            // q_lsb is still the pre-shift Q[0] at this edge.
            qm1_d   = bus.q_lsb;
            state_d = cnt_last ? S_OUT_A : S_OP;
         end
         S_OUT_A:  state_d = S_OUT_Q;
         S_OUT_Q:  state_d = S_END;
         S_END:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM state and Q[-1] flop; reset aborts any operation immediately.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         qm1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         qm1_q   <= qm1_d;
      end
   end

   // Strobe decode from the state register; OP also looks at {Q[0], Q[-1]}.
   always_comb begin
      strobe = '0;
      case (state_q)
         S_LOAD_M: begin
            strobe[C_CLR_A]  = 1'b1;
            strobe[C_LOAD_M] = 1'b1;
         end
         S_LOAD_Q: strobe[C_LOAD_Q] = 1'b1;
         S_OP: begin
            case ({bus.q_lsb, qm1_q})
               2'b10:   strobe[C_SUB] = 1'b1;
               2'b01:   strobe[C_ADD] = 1'b1;
               default: ;  // 00 / 11: NOP iteration
            endcase
         end
         S_SHIFT:  strobe[C_SHIFT] = 1'b1;
         S_OUT_A:  strobe[C_OUT_A] = 1'b1;
         S_OUT_Q:  strobe[C_OUT_Q] = 1'b1;
         default:  ;
      endcase
   end

   assign bus.c0   = strobe[C_CLR_A];
   assign bus.c1   = strobe[C_LOAD_Q];
   assign bus.c2   = strobe[C_LOAD_M];
   assign bus.c3   = strobe[C_ADD];
   assign bus.c4   = strobe[C_SHIFT];
   assign bus.c5   = strobe[C_SUB];
   assign bus.c6   = strobe[C_OUT_Q];
   assign bus.c7   = strobe[C_OUT_A];
   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = (state_q == S_END);

endmodule

// File: tb/tb_booth_ctrl_unit.sv
// Scoreboard bench for booth_ctrl_unit: a behavioural A/Q/M datapath reacts
// to the strobes, expected events are queued at launch and popped by a monitor.
module tb_booth_ctrl_unit;

   typedef enum int {EV_OP, EV_A, EV_Q, EV_DONE, EV_BUSY} ev_e;
   typedef struct {
      ev_e kind;
      int  val;
   } ev_t;

   logic        clk;
   logic        rst_b;
   int          cyc;
   int          checks;
   int          errors;
   ev_t         sb_q[$];

   logic [15:0] mcand, mplier;
   logic [15:0] a_m, q_m, m_m;

   booth_ctrl_unit_if bus();

   booth_ctrl_unit #(.w(16)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural A/Q/M registers driven by the strobes.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         a_m <= '0;
         q_m <= '0;
         m_m <= '0;
      end else begin
         if (bus.c0) a_m <= '0;
         if (bus.c2) m_m <= mcand;
         if (bus.c1) q_m <= mplier;
         if (bus.c3) a_m <= a_m + m_m;
         if (bus.c5) a_m <= a_m - m_m;
         if (bus.c4) begin
            a_m <= {a_m[15], a_m[15:1]};
            q_m <= {a_m[0], q_m[15:1]};
         end
      end
   end

   assign bus.q_lsb = q_m[0];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pop_cmp(input ev_e kind, input int act, input string name);
      ev_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event value %0h, queue empty (cycle %0d)", name, act, cyc);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.val !== act) begin
            errors++;
            $display("FAIL %s: got kind %0d value %0h expected kind %0d value %0h (cycle %0d)",
                     name, kind, act, e.kind, e.val, cyc);
         end
      end
   endtask

   function automatic int outs();
      return int'({bus.done, bus.busy, bus.c7, bus.c6, bus.c5, bus.c4,
                   bus.c3, bus.c2, bus.c1, bus.c0});
   endfunction

   // Monitor: sample mid-cycle, pop expectations as the DUT produces events.
   int  busy_run  = 0;
   bit  prev_busy = 1'b0;
   bit  prev_done = 1'b0;
   int  prev_op   = 0;
   always @(negedge clk) begin
      automatic int  cur_op = bus.c5 ? 2 : (bus.c3 ? 1 : 0);
      automatic bit  ok = $onehot0({bus.c7, bus.c6, bus.c5, bus.c4, bus.c3, bus.c2, bus.c1})
                          && (bus.c0 == bus.c2) && !(bus.done && prev_done);
      check("strobe_rules", int'(ok), 1);
      if (bus.c4) pop_cmp(EV_OP, prev_op, "op_decode");
      if (bus.c7) pop_cmp(EV_A, int'(a_m), "out_a");
      if (bus.c6) pop_cmp(EV_Q, int'(q_m), "out_q");
      if (bus.done) pop_cmp(EV_DONE, cyc, "done_cycle");
      if (bus.busy)
         busy_run++;
      else if (prev_busy) begin
         pop_cmp(EV_BUSY, busy_run, "busy_len");
         busy_run = 0;
      end
      prev_busy = bus.busy;
      prev_done = bus.done;
      prev_op   = cur_op;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Queue the events of one multiply whose start is sampled at the edge
   // that ends slot m: per-iteration op (0 NOP, 1 add, 2 sub), then A, Q,
   // done slot and busy length; an aborted run gets only n_it ops and busylen.
   task automatic push_exp(input logic [15:0] sub_m, input logic [15:0] add_m,
                           input int n_it, input bit full,
                           input logic [15:0] exp_a, input logic [15:0] exp_q,
                           input int m, input int busylen);
      for (int k = 0; k < n_it; k++)
         sb_q.push_back('{EV_OP, sub_m[k] ? 2 : (add_m[k] ? 1 : 0)});
      if (full) begin
         sb_q.push_back('{EV_A, int'(exp_a)});
         sb_q.push_back('{EV_Q, int'(exp_q)});
         sb_q.push_back('{EV_DONE, m + 37});
      end
      sb_q.push_back('{EV_BUSY, busylen});
   endtask

   task automatic launch(input logic [15:0] mc, input logic [15:0] mp,
                         input logic [15:0] sub_m, input logic [15:0] add_m,
                         input logic [15:0] exp_a, input logic [15:0] exp_q);
      mcand     = mc;
      mplier    = mp;
      bus.start = 1'b1;
      push_exp(sub_m, add_m, 16, 1'b1, exp_a, exp_q, cyc, 37);
   endtask

   task automatic run(input logic [15:0] mc, input logic [15:0] mp,
                      input logic [15:0] sub_m, input logic [15:0] add_m,
                      input logic [15:0] exp_a, input logic [15:0] exp_q);
      launch(mc, mp, sub_m, add_m, exp_a, exp_q);
      tick();
      bus.start = 1'b0;
      ticks(40);
   endtask

   initial begin
      int m;
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      mcand     = '0;
      mplier    = '0;
      rst_b     = 1'b0;
      bus.start = 1'b1;

      // Reset held with start high: nothing moves.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_outs", outs(), 0);
      end
      rst_b     = 1'b1;
      bus.start = 1'b0;
      tick();
      check("idle_after_reset", outs(), 0);

      // 3 x 5: sub in iters 0,2; add in iters 1,3.
      run(16'h0003, 16'h0005, 16'h0005, 16'h000A, 16'h0000, 16'h000F);
      // -3 x 7
      run(16'hFFFD, 16'h0007, 16'h0001, 16'h0008, 16'hFFFF, 16'hFFEB);
      // Multiplier all ones: only iteration 0 subtracts.
      run(16'h0005, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFB);
      // Multiplier 8000: only iteration 15 subtracts.
      run(16'h0002, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000);

      // start pulses in cycles 5 and 20 must not disturb a 7 x 3.
      launch(16'h0007, 16'h0003, 16'h0001, 16'h0004, 16'h0000, 16'h0015);
      tick();
      bus.start = 1'b0;
      ticks(4);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      ticks(14);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      ticks(20);

      // Reset during iteration 5 (OP at cycle 13): everything drops at once.
      mcand     = 16'h0003;
      mplier    = 16'h0005;
      bus.start = 1'b1;
      push_exp(16'h0005, 16'h000A, 5, 1'b0, 16'h0000, 16'h0000, cyc, 13);
      tick();
      bus.start = 1'b0;
      ticks(12);
      rst_b = 1'b0;
      #1;
      check("abort_outs", outs(), 0);
      tick();
      rst_b = 1'b1;
      ticks(2);
      run(16'h0003, 16'h0005, 16'h0005, 16'h000A, 16'h0000, 16'h000F);

      // start held high: second LOAD_M two cycles after END.
      m = cyc;
      launch(16'hFFFD, 16'h0007, 16'h0001, 16'h0008, 16'hFFFF, 16'hFFEB);
      push_exp(16'h0001, 16'h0008, 16, 1'b1, 16'hFFFF, 16'hFFEB, m + 38, 37);
      ticks(39);
      bus.start = 1'b0;
      ticks(40);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/booth_ctrl_unit.md
# booth_ctrl_unit

Sequencing control unit for the radix-2 Booth signed multiplier built from the A, Q and M registers of the ALU-64 datapath. It accepts a start pulse and asserts the register control strobes c0..c7 in a fixed order: load operands, perform w add/subtract-and-shift iterations, then drive A and Q onto outbus. It holds the Booth Q[-1] flop, which it updates from Q_lsb on every shift, and it reports completion with a done pulse.

## Interface
- w, 16: operand width; iteration count; w ≥ 2
- CW, $clog2(w): iteration counter width (derived, not overridden)
- clk  in  1  system clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- q_lsb  in  1  Q[0] from the Q register (its Q_lsb output)
- c0  out  1  clear A register
- c1  out  1  load Q from inbus (multiplier)
- c2  out  1  load M from inbus (multiplicand)
- c3  out  1  A <= A + M
- c4  out  1  arithmetic shift right A:Q, with A_lsb going into Q msb
- c5  out  1  A <= A - M
- c6  out  1  drive Q onto outbus (low product half)
- c7  out  1  drive A onto outbus (high product half)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD_M, LOAD_Q, OP, SHIFT, OUT_A, OUT_Q, END.
- IDLE: all strobes low. If start = 1 at a rising edge, the next state is LOAD_M. Otherwise the FSM stays in IDLE.
- LOAD_M: c0 = 1 and c2 = 1. Clears qm1 and the counter. The environment presents the multiplicand on inbus during this cycle.
- LOAD_Q: c1 = 1. The environment presents the multiplier on inbus.
- OP: decodes {q_lsb, qm1}:
  - 10: c5 = 1 (subtract)
  - 01: c3 = 1 (add)
  - 00 or 11: no strobe (NOP cycle)
  - OP always lasts exactly one cycle.
- SHIFT: c4 = 1. At the edge, qm1 <= q_lsb (the pre-shift value) and cnt <= cnt + 1.
  - If cnt == w-1 before the increment, the next state is OUT_A; otherwise it is OP.
- OUT_A: c7 = 1.
- OUT_Q: c6 = 1.
- END: done = 1, then the FSM returns to IDLE.
- Strobes are Moore outputs decoded from the state register. At most one of c1..c7 is high in any cycle. c0 is only ever paired with c2.
- start is ignored while busy = 1. start held high continuously re-triggers a new multiply from END → IDLE → LOAD_M.
- The counter counts 0..w-1 and never wraps during an operation. It is cleared in LOAD_M.

## Timing
- Reset (async, rst_b = 0): state = IDLE, cnt = 0, qm1 = 0, and all of c0..c7, busy and done = 0 immediately, without waiting for a clock edge.
- Reset asserted mid-operation aborts the multiply at once. The datapath contents are then undefined, and no done pulse is produced.
- Let start be sampled at edge 0:
  - LOAD_M occupies cycle 1, LOAD_Q cycle 2.
  - Iteration k (k = 0..w-1) has OP at cycle 3+2k and SHIFT at cycle 4+2k.
  - OUT_A is at cycle 2w+3, OUT_Q at 2w+4, END at 2w+5.
  - For w = 16, done is high in cycle 37, and busy is high for cycles 1..37 (37 cycles).
- q_lsb is sampled combinationally in OP, and at the edge ending SHIFT. It must be stable one setup time before those edges.
- Latency is fixed and does not depend on the operands.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE..END, 3-bit encoding)
  - the named indices of the control strobes C_CLR_A = 0 … C_OUT_A = 7
- Sub-module booth_iter_cnt: parameterized w / CW, with clear, increment and a last flag (cnt == w-1). It is instantiated once.
- FSM, qm1 flop and output decode live in booth_ctrl_unit.

## Test plan
- Reset: hold rst_b = 0 with start = 1 → all outputs 0, no state change. Pulse rst_b low during iteration 5 → all strobes and busy drop at once, and the next start resumes the normal sequence.
- Sequence check, w = 16: the bench models reg_Q with multiplier 16'h0005 and M = 3.
  - Required OP strobes: c5 in iterations 0 and 2, c3 in iterations 1 and 3, none in iterations 4..15.
  - Product on outbus: A = 16'h0000, Q = 16'h000F.
  - done in cycle 37.
- Negative operands: −3 × 7 with a modeled datapath → outbus gives A = 16'hFFFF then Q = 16'hFFEB. Exactly one c3/c5/NOP per OP cycle.
- Boundary: multiplier 16'hFFFF → only iteration 0 strobes (c5); iterations 1..15 are NOP. Multiplier 16'h8000 → only iteration 15 strobes (c5).
- Start while busy: pulse start in cycles 5 and 20 → no effect and no timing shift. start held high → back-to-back operations with LOAD_M two cycles after END.
- Strobe exclusivity: every cycle, assert at most one of c1..c7, c0 only together with c2, busy == (state != IDLE), and done high for exactly one cycle.
